// File: rtl/tlp2axis.sv
// Memory-write TLP to AXI-Stream bridge: one header beat (address) then the payload beats.
// Defining TLP2AXIS_STATS_EN adds the tlp_count/dw_count completion counters.
module tlp2axis #(
    parameter int MAX_PCIE_PAYLOAD_SIZE = 128
) (
    input  logic        axi_clk,
    input  logic        axi_reset,
    input  logic        tlp_req_to_send,
    output logic        tlp_grant,
    input  logic [6:0]  tlp_fmt_type,
    input  logic [9:0]  tlp_length_in_dw,
    input  logic [63:0] tlp_address,
    input  logic [7:0]  tlp_ldwbe_fdwbe,
    input  logic        tlp_src_rdy_n,
    output logic        tlp_dst_rdy_n,
    input  logic [63:0] tlp_data,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [1:0]  m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        err_fmt,
    output logic        err_length
`ifdef TLP2AXIS_STATS_EN
    ,
    output logic [31:0] tlp_count,
    output logic [31:0] dw_count
`endif
);

    localparam logic [12:0] MAX_BYTES = 13'(MAX_PCIE_PAYLOAD_SIZE);
    localparam logic [6:0]  FMT_MWR32 = 7'h40;
    localparam logic [6:0]  FMT_MWR64 = 7'h60;

    typedef enum logic [2:0] {IDLE, GRANT, HDR, DATA, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] beats_q, beats_d;
    logic [14:0] hdr_meta_q, hdr_meta_d;
    logic        valid_q, valid_d;
    logic [63:0] data_q, data_d;
    logic [1:0]  user_q, user_d;
    logic        last_q, last_d;
    logic        err_fmt_q, err_fmt_d;
    logic        err_len_q, err_len_d;

    logic [10:0] len_eff;
    logic [10:0] beats_in;
    logic        fmt_bad;
    logic        len_bad;
    logic        out_xfer;
    logic        beat_xfer;
    logic        last_in;

    assign m_axis_tvalid = valid_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tlast  = last_q;
    assign err_fmt       = err_fmt_q;
    assign err_length    = err_len_q;

    always_comb begin
        len_eff  = (tlp_length_in_dw == '0) ? 11'd1024 : {1'b0, tlp_length_in_dw};
        beats_in = (len_eff + 11'd1) >> 1;
        fmt_bad  = (tlp_fmt_type != FMT_MWR32) && (tlp_fmt_type != FMT_MWR64);
        len_bad  = {len_eff, 2'b00} > MAX_BYTES;
        out_xfer = valid_q && m_axis_tready;
        last_in  = (cnt_q == beats_q - 11'd1);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        beats_d       = beats_q;
        hdr_meta_d    = hdr_meta_q;
        valid_d       = valid_q;
        data_d        = data_q;
        user_d        = user_q;
        last_d        = last_q;
        err_fmt_d     = 1'b0;
        err_len_d     = 1'b0;
        tlp_grant     = 1'b0;
        tlp_dst_rdy_n = 1'b1;
        beat_xfer     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tlp_req_to_send) state_d = GRANT;
            end
            GRANT: begin
                tlp_grant  = 1'b1;
                cnt_d      = '0;
                beats_d    = beats_in;
                // fmt/byte enables are held for debug visibility; nothing downstream consumes them
                hdr_meta_d = {tlp_fmt_type, tlp_ldwbe_fdwbe};
                err_fmt_d  = fmt_bad;
                err_len_d  = len_bad;
                if (fmt_bad || len_bad) begin
                    state_d = DRAIN;
                end else begin
                    state_d = HDR;
                    valid_d = 1'b1;
                    data_d  = tlp_address;
                    user_d  = 2'b01;
                    last_d  = 1'b0;
                end
            end
            HDR: begin
                if (out_xfer) begin
                    state_d = DATA;
                    valid_d = 1'b0;
                end
            end
            DATA: begin
                // stop accepting once every payload beat is in, so the next TLP's data is never swallowed
                tlp_dst_rdy_n = !((!valid_q || m_axis_tready) && (cnt_q != beats_q));
                beat_xfer     = !tlp_src_rdy_n && !tlp_dst_rdy_n;
                if (out_xfer) valid_d = 1'b0;
                if (beat_xfer) begin
                    valid_d = 1'b1;
                    data_d  = tlp_data;
                    user_d  = 2'b00;
                    last_d  = last_in;
                    cnt_d   = cnt_q + 11'd1;
                end
                if (out_xfer && last_q) state_d = IDLE;
            end
            DRAIN: begin
                tlp_dst_rdy_n = 1'b0;
                beat_xfer     = !tlp_src_rdy_n;
                if (beat_xfer) begin
                    cnt_d = cnt_q + 11'd1;
                    if (last_in) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            beats_q    <= '0;
            hdr_meta_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            user_q     <= '0;
            last_q     <= 1'b0;
            err_fmt_q  <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beats_q    <= beats_d;
            hdr_meta_q <= hdr_meta_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            user_q     <= user_d;
            last_q     <= last_d;
            err_fmt_q  <= err_fmt_d;
            err_len_q  <= err_len_d;
        end
    end

`ifdef TLP2AXIS_STATS_EN
    logic [10:0] len_q, len_d;
    logic [31:0] tlp_cnt_q, tlp_cnt_d;
    logic [31:0] dw_cnt_q, dw_cnt_d;

    always_comb begin
        len_d     = len_q;
        tlp_cnt_d = tlp_cnt_q;
        dw_cnt_d  = dw_cnt_q;
        if (state_q == GRANT) len_d = len_eff;
        if (state_q == DATA && out_xfer && last_q) begin
            tlp_cnt_d = tlp_cnt_q + 32'd1;
            dw_cnt_d  = dw_cnt_q + {21'b0, len_q};
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            len_q     <= '0;
            tlp_cnt_q <= '0;
            dw_cnt_q  <= '0;
        end else begin
            len_q     <= len_d;
            tlp_cnt_q <= tlp_cnt_d;
            dw_cnt_q  <= dw_cnt_d;
        end
    end

    assign tlp_count = tlp_cnt_q;
    assign dw_count  = dw_cnt_q;
`endif

endmodule

// File: tb/tb_tlp2axis.sv
// Bench for tlp2axis: table of TLP requests plus a mid-packet reset sequence, checked by a beat scoreboard.
module tb_tlp2axis;

    logic        axi_clk = 1'b0;
    logic        axi_reset;
    logic        tlp_req_to_send;
    logic        tlp_grant;
    logic [6:0]  tlp_fmt_type;
    logic [9:0]  tlp_length_in_dw;
    logic [63:0] tlp_address;
    logic [7:0]  tlp_ldwbe_fdwbe;
    logic        tlp_src_rdy_n;
    logic        tlp_dst_rdy_n;
    logic [63:0] tlp_data;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [63:0] m_axis_tdata;
    logic [1:0]  m_axis_tuser;
    logic        m_axis_tlast;
    logic        err_fmt;
    logic        err_length;
`ifdef TLP2AXIS_STATS_EN
    logic [31:0] tlp_count;
    logic [31:0] dw_count;
`endif

    always #5 axi_clk = ~axi_clk;

    tlp2axis #(.MAX_PCIE_PAYLOAD_SIZE(128)) dut (
        .axi_clk         (axi_clk),
        .axi_reset       (axi_reset),
        .tlp_req_to_send (tlp_req_to_send),
        .tlp_grant       (tlp_grant),
        .tlp_fmt_type    (tlp_fmt_type),
        .tlp_length_in_dw(tlp_length_in_dw),
        .tlp_address     (tlp_address),
        .tlp_ldwbe_fdwbe (tlp_ldwbe_fdwbe),
        .tlp_src_rdy_n   (tlp_src_rdy_n),
        .tlp_dst_rdy_n   (tlp_dst_rdy_n),
        .tlp_data        (tlp_data),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tlast    (m_axis_tlast),
        .err_fmt         (err_fmt),
        .err_length      (err_length)
`ifdef TLP2AXIS_STATS_EN
        ,
        .tlp_count       (tlp_count),
        .dw_count        (dw_count)
`endif
    );

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  u;
        logic        l;
    } beat_t;

    typedef struct {
        logic [6:0]  fmt;
        logic [9:0]  len;
        logic [63:0] addr;
        int unsigned rdy_mode;
        bit          rnd_src;
        int unsigned exp_in;
        int unsigned exp_out;
        bit          exp_ef;
        bit          exp_el;
    } vec_t;

    beat_t       sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          n_grant  = 0;
    int          n_ef     = 0;
    int          n_el     = 0;
    int          n_acc    = 0;
    int          n_data   = 0;
    int          n_hdr    = 0;
    int          n_last   = 0;
    int unsigned rdy_mode = 0;
    bit          prev_stall = 1'b0;
    beat_t       prev_beat;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Downstream ready pattern: 0 = always ready, 1 = toggle, 2 = random
    always @(posedge axi_clk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = ($urandom_range(0, 1) == 1);
        endcase
    end

    always @(negedge axi_clk) begin
        beat_t cur;
        beat_t exp;
        cur.d = m_axis_tdata;
        cur.u = m_axis_tuser;
        cur.l = m_axis_tlast;
        if (axi_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_while_stalled", {60'b0, m_axis_tvalid, cur}, {60'b0, 1'b1, prev_beat});
            if (tlp_grant) n_grant++;
            if (err_fmt) n_ef++;
            if (err_length) n_el++;
            if (!tlp_src_rdy_n && !tlp_dst_rdy_n) n_acc++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none", cur);
                end else begin
                    exp = sb_q.pop_front();
                    check("axis_beat", 128'(cur), 128'(exp));
                end
                if (m_axis_tuser == 2'b00) n_data++;
                if (m_axis_tuser == 2'b01) n_hdr++;
                if (m_axis_tlast) n_last++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = cur;
        end
    end

    // Entered and left at posedge+1. abort_after>0 stops after that many accepted payload beats.
    task automatic send_tlp(input logic [6:0] fmt, input logic [9:0] len, input logic [63:0] addr,
                            input bit rnd, input bit legal, input int unsigned abort_after,
                            output int unsigned gwait);
        int unsigned lenw;
        int unsigned beats;
        int unsigned k;
        int unsigned cyc;
        beat_t       b;
        lenw  = (len == 10'd0) ? 1024 : int'(len);
        beats = (lenw + 1) / 2;

        tlp_req_to_send  = 1'b1;
        tlp_fmt_type     = fmt;
        tlp_length_in_dw = len;
        tlp_address      = addr;
        tlp_ldwbe_fdwbe  = 8'hFF;
        gwait = 0;
        while (gwait < 20) begin
            @(negedge axi_clk);
            if (tlp_grant) break;
            gwait++;
        end
        if (gwait >= 20) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout actual=none required=grant");
        end
        if (legal) begin
            b.d = addr; b.u = 2'b01; b.l = 1'b0;
            sb_q.push_back(b);
        end
        @(posedge axi_clk); #1;
        tlp_req_to_send  = 1'b0;
        tlp_fmt_type     = 7'h7F;
        tlp_length_in_dw = 10'h3FF;
        tlp_address      = '1;

        k   = 0;
        cyc = 0;
        while (k < beats && cyc < 3000 && !(abort_after != 0 && k == abort_after)) begin
            tlp_src_rdy_n = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            tlp_data      = {$urandom, $urandom};
            @(negedge axi_clk);
            if (!tlp_src_rdy_n && !tlp_dst_rdy_n) begin
                if (legal) begin
                    b.d = tlp_data; b.u = 2'b00; b.l = (k == beats - 1);
                    sb_q.push_back(b);
                end
                k++;
            end
            cyc++;
            @(posedge axi_clk); #1;
        end
        tlp_src_rdy_n = 1'b1;
        if (abort_after != 0) return;
        if (k < beats) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout actual=%0d required=%0d", k, beats);
        end

        // Offer two surplus beats that must not be taken
        repeat (2) begin
            tlp_src_rdy_n = 1'b0;
            tlp_data      = {$urandom, $urandom};
            @(posedge axi_clk); #1;
        end
        tlp_src_rdy_n = 1'b1;

        cyc = 0;
        while ((sb_q.size() != 0 || m_axis_tvalid) && cyc < 400) begin
            @(negedge axi_clk); #1;
            cyc++;
        end
        @(negedge axi_clk); #1;
        check("idle_after_tlp", {126'b0, tlp_dst_rdy_n, m_axis_tvalid}, {126'b0, 1'b1, 1'b0});
        check("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        @(posedge axi_clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[10];
        int unsigned gw;
        int          g0, ef0, el0, acc0, d0, h0, l0;
        bit          legal;
        int unsigned exp_tlp;
        int unsigned exp_dw;

        vecs[0] = '{7'h60, 10'd32, 64'h0000_0000_A000_0000, 0, 1'b0, 16, 16, 1'b0, 1'b0};
        vecs[1] = '{7'h40, 10'd1,  64'h0000_0000_0000_1234, 0, 1'b0, 1,  1,  1'b0, 1'b0};
        vecs[2] = '{7'h40, 10'd3,  64'h0000_0000_0000_4560, 2, 1'b1, 2,  2,  1'b0, 1'b0};
        vecs[3] = '{7'h60, 10'd32, 64'h1234_5678_9ABC_DEF0, 1, 1'b1, 16, 16, 1'b0, 1'b0};
        vecs[4] = '{7'h00, 10'd4,  64'h0000_0000_0000_0100, 0, 1'b0, 2,  0,  1'b1, 1'b0};
        vecs[5] = '{7'h40, 10'd33, 64'h0000_0000_0000_0200, 0, 1'b0, 17, 0,  1'b0, 1'b1};
        vecs[6] = '{7'h20, 10'd33, 64'h0000_0000_0000_0300, 0, 1'b1, 17, 0,  1'b1, 1'b1};
        vecs[7] = '{7'h60, 10'd0,  64'h0000_0000_0000_0400, 0, 1'b0, 512, 0, 1'b0, 1'b1};
        vecs[8] = '{7'h60, 10'd31, 64'hFFFF_0000_0000_0800, 2, 1'b1, 16, 16, 1'b0, 1'b0};
        vecs[9] = '{7'h40, 10'd2,  64'h0000_0000_0000_0C00, 1, 1'b0, 1,  1,  1'b0, 1'b0};

        axi_reset        = 1'b1;
        tlp_req_to_send  = 1'b1;
        tlp_fmt_type     = 7'h60;
        tlp_length_in_dw = 10'd2;
        tlp_address      = '0;
        tlp_ldwbe_fdwbe  = '0;
        tlp_src_rdy_n    = 1'b1;
        tlp_data         = '0;
        exp_tlp          = 0;
        exp_dw           = 0;

        repeat (3) @(posedge axi_clk);
        @(negedge axi_clk);
        check("reset_ctrl", {120'b0, tlp_grant, tlp_dst_rdy_n, m_axis_tvalid, m_axis_tlast,
                             m_axis_tuser, err_fmt, err_length}, {120'b0, 8'b0100_0000});
        check("reset_tdata", 128'(m_axis_tdata), 128'(0));
        @(posedge axi_clk); #1;
        tlp_req_to_send = 1'b0;
        axi_reset       = 1'b0;
        @(posedge axi_clk); #1;

        for (int i = 0; i < 10; i++) begin
            rdy_mode = vecs[i].rdy_mode;
            legal    = !(vecs[i].exp_ef || vecs[i].exp_el);
            g0 = n_grant; ef0 = n_ef; el0 = n_el; acc0 = n_acc; d0 = n_data; h0 = n_hdr; l0 = n_last;
            send_tlp(vecs[i].fmt, vecs[i].len, vecs[i].addr, vecs[i].rnd_src, legal, 0, gw);
            check($sformatf("v%0d_grant_latency", i), 128'(gw), 128'(1));
            check($sformatf("v%0d_grant_pulses", i), 128'(n_grant - g0), 128'(1));
            check($sformatf("v%0d_err_fmt", i), 128'(n_ef - ef0), 128'(vecs[i].exp_ef));
            check($sformatf("v%0d_err_length", i), 128'(n_el - el0), 128'(vecs[i].exp_el));
            check($sformatf("v%0d_beats_accepted", i), 128'(n_acc - acc0), 128'(vecs[i].exp_in));
            check($sformatf("v%0d_data_beats_out", i), 128'(n_data - d0), 128'(vecs[i].exp_out));
            check($sformatf("v%0d_header_beats", i), 128'(n_hdr - h0), 128'(legal));
            check($sformatf("v%0d_tlast_count", i), 128'(n_last - l0), 128'(vecs[i].exp_out != 0));
            if (legal) begin
                exp_tlp++;
                exp_dw += (vecs[i].len == 10'd0) ? 1024 : int'(vecs[i].len);
            end
        end

`ifdef TLP2AXIS_STATS_EN
        check("stats_tlp_count", 128'(tlp_count), 128'(exp_tlp));
        check("stats_dw_count", 128'(dw_count), 128'(exp_dw));
`endif

        // Reset after payload beat 5 of a 16-beat TLP, then a 2-DW TLP straight out of reset
        rdy_mode = 0;
        l0 = n_last;
        send_tlp(7'h60, 10'd32, 64'h0000_0000_B000_0000, 1'b0, 1'b1, 5, gw);
        axi_reset = 1'b1;
        @(posedge axi_clk);
        @(negedge axi_clk);
        check("reset_drops_tvalid", 128'(m_axis_tvalid), 128'(0));
        @(posedge axi_clk); #1;
        sb_q.delete();
        axi_reset = 1'b0;
        g0 = n_grant; d0 = n_data;
        send_tlp(7'h40, 10'd2, 64'h0000_0000_0000_C0DE, 1'b0, 1'b1, 0, gw);
        check("post_reset_grant_latency", 128'(gw), 128'(1));
        check("post_reset_grant_pulses", 128'(n_grant - g0), 128'(1));
        check("post_reset_data_beats", 128'(n_data - d0), 128'(1));
        check("post_reset_tlast_count", 128'(n_last - l0), 128'(1));
`ifdef TLP2AXIS_STATS_EN
        check("stats_after_reset_tlp", 128'(tlp_count), 128'(1));
        check("stats_after_reset_dw", 128'(dw_count), 128'(2));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlp2axis.md
TLP2AXIS -- requirements
Module: tlp2axis

Interface
REQ-001 The block SHALL take parameter MAX_PCIE_PAYLOAD_SIZE, default 128, the largest accepted payload in bytes (legal values 128, 256, 512).
REQ-002 The block SHALL have port axi_clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port axi_reset, input, 1, reset; synchronous and active-high.
REQ-004 The block SHALL have port tlp_req_to_send, input, 1, the initiator has a write TLP pending.
REQ-005 The block SHALL have port tlp_grant, output, 1, a one-cycle grant pulse.
REQ-006 The block SHALL have port tlp_fmt_type, input, 7, the TLP fmt/type field.
REQ-007 The block SHALL have port tlp_length_in_dw, input, 10, the payload length in DW, where 0 means 1024.
REQ-008 The block SHALL have port tlp_address, input, 64, the byte address.
REQ-009 The block SHALL have port tlp_ldwbe_fdwbe, input, 8, the last/first DW byte enables.
REQ-010 The block SHALL have ports tlp_src_rdy_n (input, 1) and tlp_dst_rdy_n (output, 1), the active-low data handshake.
REQ-011 The block SHALL have port tlp_data, input, 64, two payload DWs per beat.
REQ-012 The block SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tdata (output, 64), m_axis_tuser (output, 2) and m_axis_tlast (output, 1).
REQ-013 The block SHALL have ports err_fmt (output, 1) and err_length (output, 1), each a one-cycle error pulse.

Function
REQ-014 The state machine SHALL have the states IDLE, GRANT, HDR, DATA and DRAIN.
REQ-015 In IDLE with tlp_req_to_send=1, the block SHALL go to GRANT and drive tlp_grant=1 for exactly one cycle.
REQ-016 In the GRANT cycle, the block SHALL latch fmt_type, length_in_dw, address and ldwbe_fdwbe.
REQ-017 The beat count SHALL be ceil(len/2), computed 11 bits wide, with len=0 treated as 1024.
REQ-018 Legal fmt_type values SHALL be 0x40 (MWr32) and 0x60 (MWr64).
- Any other value: pulse err_fmt for one cycle after GRANT, then go to DRAIN.
REQ-019 If len*4 exceeds MAX_PCIE_PAYLOAD_SIZE, the block SHALL pulse err_length and go to DRAIN.
- If both errors apply, it SHALL pulse both.
REQ-020 For a legal TLP, the block SHALL go to HDR and present one header beat:
- tdata = latched address;
- tuser = 2'b01;
- tlast = 0.
REQ-021 In HDR, the block SHALL go to DATA when m_axis_tvalid and m_axis_tready are both 1.
REQ-022 A TLP beat SHALL transfer when tlp_src_rdy_n=0 and tlp_dst_rdy_n=0.
- In DATA: tlp_dst_rdy_n = NOT(m_axis_tvalid=0 OR m_axis_tready=1).
- In DRAIN: tlp_dst_rdy_n=0.
- Elsewhere: tlp_dst_rdy_n=1.
REQ-023 Each accepted DATA beat SHALL appear on m_axis exactly one cycle later, registered.
- tuser = 2'b00.
- tlast = 1 on the final beat, otherwise 0.
REQ-024 The block SHALL hold m_axis_tdata, m_axis_tuser and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 In DRAIN, the block SHALL accept and discard the beat count of beats, with no m_axis output.
REQ-026 After the final beat, the block SHALL return to IDLE; from DATA, it returns once the tlast beat has been accepted on m_axis.
REQ-027 A tlp_req_to_send that arrives outside IDLE SHALL be ignored until the block is back in IDLE; the block never grants twice per TLP.
REQ-028 In DATA or DRAIN, a cycle with tlp_src_rdy_n=1 SHALL NOT advance the beat counter.

Reset
REQ-029 While axi_reset=1, the following SHALL hold:
- the state is IDLE;
- tlp_grant=0 and tlp_dst_rdy_n=1;
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0 and m_axis_tdata=0;
- err_fmt=0 and err_length=0;
- all counters are 0.
REQ-030 A reset asserted mid-packet SHALL discard the partial packet with no tlast emitted, and the block SHALL then accept a new request on the first cycle after reset deasserts.

Configuration
REQ-031 When the macro TLP2AXIS_STATS_EN is defined, the block SHALL add two outputs, both cleared by reset:
- tlp_count (32): legal TLPs completed, incremented when the tlast beat is accepted;
- dw_count (32): DWs forwarded, incremented by len at the same point, wrapping modulo 2^32.
REQ-032 When TLP2AXIS_STATS_EN is undefined, the ports tlp_count and dw_count SHALL NOT exist and no counter logic SHALL be present.

Verification
REQ-033 A 32-DW MWr64 to 0xA0000000 with m_axis_tready held at 1 SHALL produce:
- a header beat carrying 0xA0000000;
- 16 data beats with tuser=00;
- tlast on beat 16;
- exactly one tlp_grant pulse.
REQ-034 A 32-DW packet with m_axis_tready toggling 1/0 every cycle and tlp_src_rdy_n randomly deasserted SHALL produce data identical in order, with no loss or duplication.
REQ-035 A request with fmt_type=0x00 and len=4 SHALL produce:
- an err_fmt pulse;
- 2 beats drained;
- no m_axis_tvalid;
- a return to IDLE.
REQ-036 A request with len=33 and MAX_PCIE_PAYLOAD_SIZE=128 SHALL produce:
- an err_length pulse;
- 17 beats drained.
REQ-037 A reset asserted after data beat 5 of 16 SHALL:
- drop m_axis_tvalid on the next edge;
- grant a new 2-DW TLP after reset deasserts, delivered with tlast on its single data beat.
REQ-038 With TLP2AXIS_STATS_EN defined, three legal 32-DW TLPs SHALL give tlp_count=3 and dw_count=96.
